// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: push-button setting controller for a 24-hour alarm clock.
//
// The user edits hours and then minutes for either the running time or the
// alarm. The edit value drives the clock's BCD load bus, and a one-cycle
// LDT/LDA strobe tells the clock core to load it. An edit with no MODE/INC
// activity for TIMEOUT_CYC cycles is dropped and no load is issued.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   BTN_TIME / BTN_ALM    rising edge in IDLE starts a time / alarm edit
//   BTN_MODE              rising edge steps hours -> minutes -> commit
//   BTN_INC               rising edge increments the selected field (wraps)
//   CUR_H2..CUR_M1        running time from the core (BCD), start of a time edit
//   Hpoz2..Mpoz1          BCD load bus (tens/units of hours and minutes)
//   LDT / LDA             one-cycle time / alarm load strobes
//   EDITING               high in EDIT_H, EDIT_M and COMMIT
//   FIELD                 0 = hours selected, 1 = minutes selected
//   TARGET                0 = time, 1 = alarm
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTN_TIME,
  input  logic       BTN_ALM,
  input  logic       BTN_MODE,
  input  logic       BTN_INC,
  input  logic [1:0] CUR_H2,
  input  logic [3:0] CUR_H1,
  input  logic [3:0] CUR_M2,
  input  logic [3:0] CUR_M1,
  output logic [1:0] Hpoz2,
  output logic [3:0] Hpoz1,
  output logic [3:0] Mpoz2,
  output logic [3:0] Mpoz1,
  output logic       LDT,
  output logic       LDA,
  output logic       EDITING,
  output logic       FIELD,
  output logic       TARGET
);

  typedef enum logic [1:0] {StIdle, StEditH, StEditM, StCommit} state_e;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       btn_q;
  logic [3:0]       btn_rise;
  logic [4:0]       edit_h_q, edit_h_d;
  logic [5:0]       edit_m_q, edit_m_d;
  logic [4:0]       alm_h_q, alm_h_d;
  logic [5:0]       alm_m_q, alm_m_d;
  logic             target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ldt_q, ldt_d;
  logic             lda_q, lda_d;
  logic [4:0]       cur_h_bin;
  logic [5:0]       cur_m_bin;
  logic             time_rise, alm_rise, mode_rise, inc_rise;

  // btn_q is cleared in reset, so a button held through reset yields one edge after it.
  assign btn_rise  = {BTN_TIME, BTN_ALM, BTN_MODE, BTN_INC} & ~btn_q;
  assign time_rise = btn_rise[3];
  assign alm_rise  = btn_rise[2];
  assign mode_rise = btn_rise[1];
  assign inc_rise  = btn_rise[0];

  assign cur_h_bin = {3'b000, CUR_H2} * 5'd10 + {1'b0, CUR_H1};
  assign cur_m_bin = {2'b00, CUR_M2} * 6'd10 + {2'b00, CUR_M1};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      btn_q    <= '0;
      edit_h_q <= '0;
      edit_m_q <= '0;
      alm_h_q  <= '0;
      alm_m_q  <= '0;
      target_q <= 1'b0;
      cnt_q    <= '0;
      ldt_q    <= 1'b0;
      lda_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= {BTN_TIME, BTN_ALM, BTN_MODE, BTN_INC};
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
      alm_h_q  <= alm_h_d;
      alm_m_q  <= alm_m_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ldt_q    <= ldt_d;
      lda_q    <= lda_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    alm_h_d  = alm_h_q;
    alm_m_d  = alm_m_q;
    target_d = target_q;
    cnt_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (time_rise) begin
          target_d = 1'b0;
          edit_h_d = cur_h_bin;
          edit_m_d = cur_m_bin;
          state_d  = StEditH;
        end else if (alm_rise) begin
          target_d = 1'b1;
          edit_h_d = alm_h_q;
          edit_m_d = alm_m_q;
          state_d  = StEditH;
        end
      end
      StEditH: begin
        // MODE beats INC; any activity beats the timeout.
        if (mode_rise) begin
          state_d = StEditM;
        end else if (inc_rise) begin
          edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StEditM: begin
        if (mode_rise) begin
          state_d = StCommit;
        end else if (inc_rise) begin
          edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCommit: begin
        if (target_q) begin
          alm_h_d = edit_h_q;
          alm_m_d = edit_m_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Strobes are registered so they are high exactly while state_q is COMMIT.
    ldt_d = (state_d == StCommit) & ~target_d;
    lda_d = (state_d == StCommit) & target_d;
  end

  // Outputs
  always_comb begin
    EDITING = (state_q != StIdle);
    FIELD   = (state_q == StEditM);
    TARGET  = target_q;
    LDT     = ldt_q;
    LDA     = lda_q;

    if (edit_h_q >= 5'd20) begin
      Hpoz2 = 2'd2;
      Hpoz1 = 4'(edit_h_q - 5'd20);
    end else if (edit_h_q >= 5'd10) begin
      Hpoz2 = 2'd1;
      Hpoz1 = 4'(edit_h_q - 5'd10);
    end else begin
      Hpoz2 = 2'd0;
      Hpoz1 = 4'(edit_h_q);
    end

    if (edit_m_q >= 6'd50) begin
      Mpoz2 = 4'd5;
      Mpoz1 = 4'(edit_m_q - 6'd50);
    end else if (edit_m_q >= 6'd40) begin
      Mpoz2 = 4'd4;
      Mpoz1 = 4'(edit_m_q - 6'd40);
    end else if (edit_m_q >= 6'd30) begin
      Mpoz2 = 4'd3;
      Mpoz1 = 4'(edit_m_q - 6'd30);
    end else if (edit_m_q >= 6'd20) begin
      Mpoz2 = 4'd2;
      Mpoz1 = 4'(edit_m_q - 6'd20);
    end else if (edit_m_q >= 6'd10) begin
      Mpoz2 = 4'd1;
      Mpoz1 = 4'(edit_m_q - 6'd10);
    end else begin
      Mpoz2 = 4'd0;
      Mpoz1 = 4'(edit_m_q);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with an 8-cycle edit timeout.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       BTN_TIME, BTN_ALM, BTN_MODE, BTN_INC;
  logic [1:0] CUR_H2;
  logic [3:0] CUR_H1, CUR_M2, CUR_M1;
  logic [1:0] Hpoz2;
  logic [3:0] Hpoz1, Mpoz2, Mpoz1;
  logic       LDT, LDA, EDITING, FIELD, TARGET;

  int n_assert = 0;
  int n_fail   = 0;

  clock_set_ctrl #(
    .TIMEOUT_CYC(8),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .BTN_TIME(BTN_TIME),
    .BTN_ALM (BTN_ALM),
    .BTN_MODE(BTN_MODE),
    .BTN_INC (BTN_INC),
    .CUR_H2  (CUR_H2),
    .CUR_H1  (CUR_H1),
    .CUR_M2  (CUR_M2),
    .CUR_M1  (CUR_M1),
    .Hpoz2   (Hpoz2),
    .Hpoz1   (Hpoz1),
    .Mpoz2   (Mpoz2),
    .Mpoz1   (Mpoz1),
    .LDT     (LDT),
    .LDA     (LDA),
    .EDITING (EDITING),
    .FIELD   (FIELD),
    .TARGET  (TARGET)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] bcd(input int h2, input int h1, input int m2, input int m1);
    return {2'(h2), 4'(h1), 4'(m2), 4'(m1)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [13:0] exp);
    chk(tag, {2'b00, Hpoz2, Hpoz1, Mpoz2, Mpoz1}, {2'b00, exp});
  endtask

  // Sample 1 time unit after the edge, once registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: BTN_TIME = v;
      1: BTN_ALM  = v;
      2: BTN_MODE = v;
      default: BTN_INC = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
    tick();
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  localparam int BTime = 0, BAlm = 1, BMode = 2, BInc = 3;

  initial begin
    reset = 1'b1;
    BTN_TIME = 1'b0; BTN_ALM = 1'b0; BTN_MODE = 1'b0; BTN_INC = 1'b0;
    CUR_H2 = 2'd1; CUR_H1 = 4'd3; CUR_M2 = 4'd4; CUR_M1 = 4'd5;
    tick();
    tick();
    chk_bus("rst_bus", bcd(0, 0, 0, 0));
    chk("rst_strobes", {14'd0, LDT, LDA}, 16'd0);
    chk("rst_flags", {13'd0, EDITING, FIELD, TARGET}, 16'd0);
    reset = 1'b0;
    tick();
    chk("idle_editing", {15'd0, EDITING}, 16'd0);

    // Time edit from 13:45 -> 15:00
    press(BTime);
    chk("time_entry_flags", {13'd0, EDITING, FIELD, TARGET}, 16'b100);
    chk_bus("time_entry_bus", bcd(1, 3, 4, 5));
    press_n(BInc, 2);
    chk_bus("time_inc_h", bcd(1, 5, 4, 5));
    press(BMode);
    chk("time_field_m", {15'd0, FIELD}, 16'd1);
    press_n(BInc, 15);
    chk_bus("time_wrap_m", bcd(1, 5, 0, 0));
    chk("time_pre_commit", {14'd0, LDT, LDA}, 16'd0);
    BTN_MODE = 1'b1;
    tick();
    chk("time_commit_strobe", {13'd0, LDT, LDA, EDITING}, 16'b101);
    BTN_MODE = 1'b0;
    tick();
    chk("time_post_commit", {13'd0, LDT, LDA, EDITING}, 16'b000);
    chk_bus("time_bus_hold", bcd(1, 5, 0, 0));
    tick();
    chk("time_strobe_gone", {14'd0, LDT, LDA}, 16'd0);

    // Alarm edit from 00:00 with both fields wrapping back to 00:00
    press(BAlm);
    chk("alm_entry_flags", {13'd0, EDITING, FIELD, TARGET}, 16'b101);
    chk_bus("alm_entry_bus", bcd(0, 0, 0, 0));
    press_n(BInc, 24);
    chk_bus("alm_wrap_h", bcd(0, 0, 0, 0));
    press(BMode);
    press_n(BInc, 60);
    chk_bus("alm_wrap_m", bcd(0, 0, 0, 0));
    BTN_MODE = 1'b1;
    tick();
    chk("alm_commit_strobe", {14'd0, LDT, LDA}, 16'b01);
    BTN_MODE = 1'b0;
    tick();
    chk("alm_post_commit", {13'd0, LDT, LDA, EDITING}, 16'b000);

    // Second alarm edit shows shadow 00:00, then set 07:30
    press(BAlm);
    chk_bus("alm2_entry_bus", bcd(0, 0, 0, 0));
    press_n(BInc, 7);
    press(BMode);
    press_n(BInc, 30);
    BTN_MODE = 1'b1;
    tick();
    chk("alm730_strobe", {14'd0, LDT, LDA}, 16'b01);
    chk_bus("alm730_bus", bcd(0, 7, 3, 0));
    BTN_MODE = 1'b0;
    tick();

    // Shadow recall, then let that edit time out
    press(BAlm);
    chk_bus("alm_recall_bus", bcd(0, 7, 3, 0));
    chk("alm_recall_flags", {13'd0, EDITING, FIELD, TARGET}, 16'b101);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to_no_strobe", {14'd0, LDT, LDA}, 16'd0);
    end
    chk("to_last_cycle", {15'd0, EDITING}, 16'd1);
    tick();
    chk("to_idle", {13'd0, EDITING, LDT, LDA}, 16'b000);
    chk("to_target_kept", {15'd0, TARGET}, 16'd1);

    // TIME and ALM together: TIME wins
    BTN_TIME = 1'b1; BTN_ALM = 1'b1;
    tick();
    chk("both_target", {14'd0, EDITING, TARGET}, 16'b10);
    chk_bus("both_bus", bcd(1, 3, 4, 5));
    BTN_TIME = 1'b0; BTN_ALM = 1'b0;
    tick();

    // INC edge late in the window restarts the timeout
    for (int i = 0; i < 4; i++) tick();
    BTN_INC = 1'b1;
    tick();
    chk_bus("to_inc_bus", bcd(1, 4, 4, 5));
    BTN_INC = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("to_restart_held", {15'd0, EDITING}, 16'd1);
    tick();
    chk("to_restart_idle", {13'd0, EDITING, LDT, LDA}, 16'b000);
    chk_bus("to_restart_bus", bcd(1, 4, 4, 5));

    // MODE and INC together in EDIT_H: MODE wins, hours unchanged
    press(BTime);
    BTN_MODE = 1'b1; BTN_INC = 1'b1;
    tick();
    chk("modeinc_field", {15'd0, FIELD}, 16'd1);
    chk_bus("modeinc_bus", bcd(1, 3, 4, 5));
    BTN_MODE = 1'b0; BTN_INC = 1'b0;
    tick();
    press_n(BInc, 3);
    chk_bus("editm_bus", bcd(1, 3, 4, 8));

    // Reset mid-edit with BTN_TIME held through it
    reset = 1'b1;
    BTN_TIME = 1'b1;
    CUR_H2 = 2'd2; CUR_H1 = 4'd2; CUR_M2 = 4'd1; CUR_M1 = 4'd0;
    tick();
    chk("rst_mid_flags", {11'd0, EDITING, FIELD, TARGET, LDT, LDA}, 16'd0);
    chk_bus("rst_mid_bus", bcd(0, 0, 0, 0));
    reset = 1'b0;
    tick();
    chk("held_edge_entry", {13'd0, EDITING, FIELD, TARGET}, 16'b100);
    chk_bus("held_edge_bus", bcd(2, 2, 1, 0));
    for (int i = 0; i < 10; i++) tick();
    chk("held_single_edge", {15'd0, EDITING}, 16'd0);
    BTN_TIME = 1'b0;
    tick();
    press(BAlm);
    chk_bus("rst_shadow_clear", bcd(0, 0, 0, 0));
    chk("rst_shadow_target", {15'd0, TARGET}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
